serial_tx_fifo: RTL
===================

Name: serial_tx_fifo

Overview:
- Buffered UART transmitter (8N1) for the MMU-side serial port.
- The CPU writes bytes through the MMU bus handshake. They queue in a small FIFO and are shifted out LSB-first on the host-facing TX line at a fixed bit period.
- Status read gives software a non-blocking poll, so the CPU no longer stalls for a full frame on each byte.

Parameters:
- BIT_CYCLES, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ce_i  in  1  bus access request; held high until ready_o is seen.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  3  register select: 3'b000 = data, 3'b001 = status.
- data_i  in  32  write data; only [7:0] is used.
- sel_i  in  4  byte enables; only sel_i[0] matters.
- data_o  out  32  read data.
- ready_o  out  1  access complete.
- rxd  out  1  serial line to host, idle high (same line name the serial controller drives).
- tx_busy  out  1  high when the FIFO is non-empty or a frame is in flight.
- fifo_full  out  1  FIFO holds 2**FIFO_AW entries.

Behaviour:
- Reset values: data_o = 0, ready_o = 0, rxd = 1, tx_busy = 0, fifo_full = 0. FIFO pointers and count are cleared, the FSM goes to IDLE and the baud counter to 0.
- Reset mid-frame: the frame is abandoned, rxd = 1 on the next edge, and queued bytes are discarded.
- Bus handshake:
  - One transaction per ce_i assertion. An internal done flag is set when ready_o fires.
  - ready_o stays high until ce_i falls. ce_i = 0 clears done and ready_o on the next edge.
- Data write (addr 000, we_i = 1):
  - If the FIFO is not full, push data_i[7:0] when sel_i[0] = 1, and assert ready_o one cycle after ce_i is sampled.
  - If the FIFO is full, hold ready_o low (back-pressure) until a slot frees, then push and ack.
  - Full FIFO plus a pop in the same cycle: the push is accepted that cycle and count is unchanged.
  - sel_i[0] = 0: acked with no push.
- Data read (addr 000): data_o = 0, acked after 1 cycle.
- Status read (addr 001): data_o = {24'b0, count[4:0] zero-extended to 5 bits, idle, 1'b0, ~fifo_full}, acked after 1 cycle.
  - Bit 0 = space available; bit 1 = 0 (receive side is not in this block); bit 2 = idle (!tx_busy); bits 7:3 = FIFO level.
- Write to any other address: acked, no effect. Read from any other address: acked, data_o = 0.
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers; wrap-around is natural modulo overflow.
  - The count register is FIFO_AW+1 bits. fifo_full = (count == 2**FIFO_AW); empty = (count == 0).
- TX FSM. The baud counter counts 0..BIT_CYCLES-1; a bit ends when counter == BIT_CYCLES-1.
  - IDLE: rxd = 1. If the FIFO is not empty, pop into an 8-bit shift register, clear the counter, go to START. rxd goes 0 on the edge after the pop.
  - START: rxd = 0 for BIT_CYCLES cycles, then DATA with bit index 0.
  - DATA: rxd = shift[0] per bit, shifting right at each bit end; after bit index 7, go to STOP.
  - STOP: rxd = 1 for BIT_CYCLES cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Frame length = 10*BIT_CYCLES cycles.
- tx_busy = (state != IDLE) | !empty, registered.

Optional Feature:
- SERIAL_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. rxd = even parity (XOR of the 8 data bits) for BIT_CYCLES cycles; frame = 11*BIT_CYCLES.
- Not defined: no PARITY state; frame = 10*BIT_CYCLES cycles.

Test Plan (BIT_CYCLES = 4, FIFO_AW = 2):
1. rst high 2 cycles mid-frame -> rxd = 1, tx_busy = 0, status read returns 0x00000005.
2. Write 0x55 (sel_i = 4'hF) -> ready_o after 1 cycle. rxd = 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles). tx_busy falls after 40 cycles.
3. Write 0xA3, 0x0F back-to-back -> second start bit begins the cycle after the first stop bit ends; no idle gap.
4. Write 5 bytes while the line is busy -> 5th write holds ready_o low until the first pop. Then it is acked, fifo_full = 1, and the status read shows level 4 and bit0 = 0.
5. Write 0x77 with sel_i = 4'b1110 -> acked, no frame, tx_busy stays 0.
6. With SERIAL_TX_PARITY_EN, write 0x07 -> parity bit = 1, frame = 44 cycles. Write 0x03 -> parity bit = 0.

Source files
------------

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: buffered 8N1 UART transmitter behind the MMU bus handshake.
// Bytes written to the data register queue in a circular FIFO and are shifted
// out LSB-first on rxd, one bit every BIT_CYCLES clocks.
// Optional build macro: SERIAL_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit (frame becomes 11 bit periods).
// tx_state_o exposes the transmit FSM state for debug and checkers.
module serial_tx_fifo #(
    parameter int BIT_CYCLES = 434,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        rxd,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic [2:0]  tx_state_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(BIT_CYCLES);
    localparam int CNTW  = FIFO_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]    count_q, count_d;
    logic               fifo_full_w, fifo_empty_w;
    logic               push, pop;

    // transmit FSM
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               bit_end;
    logic               rxd_q, rxd_d;
    logic               busy_q, busy_d;

    // bus side
    logic               done_q;
    logic               ready_q;
    logic [31:0]        data_o_q, rdata_d;
    logic               ack;
    logic [4:0]         level_w;

    logic               unused_bits;
    assign unused_bits = ^{data_i[31:8], sel_i[3:1]};

    assign fifo_full_w  = (count_q == CNTW'(DEPTH));
    assign fifo_empty_w = (count_q == '0);
    assign bit_end      = (cnt_q == CW'(BIT_CYCLES - 1));
    assign level_w      = 5'(count_q);

    assign data_o     = data_o_q;
    assign ready_o    = ready_q;
    assign rxd        = rxd_q;
    assign tx_busy    = busy_q;
    assign fifo_full  = fifo_full_w;
    assign tx_state_o = state_q;

    // Bus handshake: the master raises ce_i and holds it (with we_i, addr_i,
    // data_i, sel_i stable) until it sees ready_o. The transfer takes effect
    // on the edge that raises ready_o; done_q blocks a second transfer while
    // ce_i stays high, and dropping ce_i clears ready_o and done_q on the next
    // edge. A data write into a full FIFO is held off (no ready_o) until the
    // transmitter pops a byte, which may happen in the very same cycle.

    // Decode the current request: push, acknowledge and read data
    always_comb begin
        push    = 1'b0;
        ack     = 1'b0;
        rdata_d = '0;
        if (ce_i && !done_q) begin
            if (we_i && addr_i == 3'b000 && sel_i[0]) begin
                if (!fifo_full_w || pop) begin
                    push = 1'b1;
                    ack  = 1'b1;
                end
            end else begin
                ack = 1'b1;
            end
            if (!we_i && addr_i == 3'b001) begin
                rdata_d = {24'b0, level_w, !busy_q, 1'b0, !fifo_full_w};
            end
        end
    end

    // Bus response registers: ready_o, done flag and captured read data
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            data_o_q <= '0;
        end else if (!ce_i) begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (ack) begin
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            data_o_q <= rdata_d;
        end
    end

    // FIFO level: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers and count; storage is not reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    logic par_q;

    // Even parity of the byte, captured when it leaves the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (pop) begin
            par_q <= ^mem_q[rd_ptr_q];
        end
    end
`endif

    // FSM state register plus registered line and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rxd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rxd_q   <= rxd_d;
            busy_q  <= busy_d;
        end
    end

    // FSM next state: bit timing, shifting, and FIFO pops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_w) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // chain the next frame straight from the stop bit
                    if (!fifo_empty_w) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: line level and busy flag for the state being entered
    always_comb begin
        rxd_d = 1'b1;
        case (state_d)
            S_START:  rxd_d = 1'b0;
            S_DATA:   rxd_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: rxd_d = par_q;
`endif
            default:  rxd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

endmodule
